// File: rtl/cgra_host_pkg.sv
// Shared types and helpers for the CGRA host-side sequencer.
//   host_state_e   : sequencer / handshake state encoding
//   DEF_*_BASE     : default byte addresses of the load and result regions
//   word_to_byte() : word index -> byte offset
package cgra_host_pkg;

  localparam int HOST_DW = 32;

  localparam logic [HOST_DW-1:0] DEF_LOAD_BASE  = 32'h0000_0000;
  localparam logic [HOST_DW-1:0] DEF_STORE_BASE = 32'h0000_1000;

  typedef enum logic [3:0] {
    IDLE, LOAD, PRE, START, WAIT_DONE, WAIT_CLR, RD, CAP, OUT
  } host_state_e;

  // Offset wraps modulo 2^HOST_DW like the rest of the address path.
  function automatic logic [HOST_DW-1:0] word_to_byte(input logic [HOST_DW-1:0] idx,
                                                      input logic [HOST_DW-1:0] step);
    return idx * step;
  endfunction

endpackage

// File: rtl/cgra_host_seq_if.sv
// Host sequencer bus bundle: command, load stream, result stream, BRAM port
// and the Start/Done handshake.
//   master : the sequencer side (drives Cmd_Ready, In_Ready, Out_*, Bram_*,
//            Computation_Start, Busy, Error)
//   slave  : the environment side (host, stream source/sink, BRAM, CGRA)
interface cgra_host_seq_if #(
  parameter int SYS_DWIDTH = 32,
  parameter int BYTE_LEN   = 4,
  parameter int LEN_W      = 12
) ();
  logic                  Cmd_Valid;
  logic                  Cmd_Ready;
  logic [LEN_W-1:0]      Cmd_Load_Len;
  logic [LEN_W-1:0]      Cmd_Store_Len;
  logic                  In_Valid;
  logic                  In_Ready;
  logic [SYS_DWIDTH-1:0] In_Data;
  logic                  Out_Valid;
  logic                  Out_Ready;
  logic [SYS_DWIDTH-1:0] Out_Data;
  logic                  Bram_En;
  logic [BYTE_LEN-1:0]   Bram_Wen;
  logic [SYS_DWIDTH-1:0] Bram_Addr;
  logic [SYS_DWIDTH-1:0] Bram_Data_To_Bram;
  logic [SYS_DWIDTH-1:0] Bram_Data_From_Bram;
  logic                  Computation_Start;
  logic                  Computation_Done;
  logic                  Busy;
  logic                  Error;

  modport master (
    input  Cmd_Valid, Cmd_Load_Len, Cmd_Store_Len, In_Valid, In_Data, Out_Ready,
           Bram_Data_From_Bram, Computation_Done,
    output Cmd_Ready, In_Ready, Out_Valid, Out_Data, Bram_En, Bram_Wen, Bram_Addr,
           Bram_Data_To_Bram, Computation_Start, Busy, Error
  );

  modport slave (
    output Cmd_Valid, Cmd_Load_Len, Cmd_Store_Len, In_Valid, In_Data, Out_Ready,
           Bram_Data_From_Bram, Computation_Done,
    input  Cmd_Ready, In_Ready, Out_Valid, Out_Data, Bram_En, Bram_Wen, Bram_Addr,
           Bram_Data_To_Bram, Computation_Start, Busy, Error
  );
endinterface

// File: rtl/cgra_start_done_hs.sv
// Four-phase Start/Done handshake with a CGRA kernel.
//   go                : pulse, begin a handshake (accepted in IDLE)
//   computation_done  : kernel done flag
//   computation_start : registered start request
//   error             : one-cycle pulse if Done is already high on entry
//   finished          : one-cycle pulse once Done has returned low
// Start only rises after Done is seen low and only falls after Done is
// seen high, so the four-phase ordering holds by construction.
module cgra_start_done_hs
  import cgra_host_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic computation_done,
  output logic computation_start,
  output logic error,
  output logic finished
);

  host_state_e state_q, state_d;
  logic start_q, start_d;
  logic error_q, error_d;
  logic finished_q, finished_d;
  logic stale_q, stale_d;  // stale Done already reported for this handshake

  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    error_d    = 1'b0;
    finished_d = 1'b0;
    stale_d    = stale_q;
    case (state_q)
      IDLE: if (go) begin
        state_d = PRE;
        stale_d = 1'b0;
      end
      PRE: begin
        if (computation_done) begin
          error_d = !stale_q;
          stale_d = 1'b1;
        end else begin
          state_d = START;
          start_d = 1'b1;
        end
      end
      START: state_d = WAIT_DONE;
      WAIT_DONE: if (computation_done) begin
        start_d = 1'b0;
        state_d = WAIT_CLR;
      end
      WAIT_CLR: if (!computation_done) begin
        finished_d = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
        start_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      error_q    <= 1'b0;
      finished_q <= 1'b0;
      stale_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      error_q    <= error_d;
      finished_q <= finished_d;
      stale_q    <= stale_d;
    end
  end

  assign computation_start = start_q;
  assign error             = error_q;
  assign finished          = finished_q;

endmodule

// File: rtl/cgra_host_seq.sv
// Host-side sequencer for a CGRA sharing a data BRAM.
// Per command: stream load words into BRAM, run one Start/Done handshake,
// read result words back and stream them out.
//   Clk, Rst : clock, synchronous active-high reset
//   bus      : cgra_host_seq_if.master (command, In/Out streams, BRAM port,
//              Computation_Start/Done, Busy, Error)
// All outputs are registered.
module cgra_host_seq
  import cgra_host_pkg::*;
#(
  parameter int                    SYS_DWIDTH = 32,
  parameter int                    BYTE_LEN   = 4,
  parameter int                    LEN_W      = 12,
  parameter logic [SYS_DWIDTH-1:0] LOAD_BASE  = DEF_LOAD_BASE,
  parameter logic [SYS_DWIDTH-1:0] STORE_BASE = DEF_STORE_BASE
) (
  input logic             Clk,
  input logic             Rst,
  cgra_host_seq_if.master bus
);

  host_state_e state_q, state_d;
  logic [LEN_W-1:0]      idx_q, idx_d, load_len_q, load_len_d, store_len_q, store_len_d;
  logic                  cmd_ready_q, cmd_ready_d, in_ready_q, in_ready_d, busy_q, busy_d;
  logic                  bram_en_q, bram_en_d;
  logic [BYTE_LEN-1:0]   bram_wen_q, bram_wen_d;
  logic [SYS_DWIDTH-1:0] bram_addr_q, bram_addr_d, bram_wdata_q, bram_wdata_d;
  logic                  out_valid_q, out_valid_d;
  logic [SYS_DWIDTH-1:0] out_data_q, out_data_d;

  logic                  hs_go, hs_finished, hs_start, hs_error;
  logic [LEN_W-1:0]      idx_inc;
  logic [SYS_DWIDTH-1:0] ld_addr, st_addr_nxt;

  assign idx_inc     = idx_q + LEN_W'(1);
  assign ld_addr     = LOAD_BASE  + SYS_DWIDTH'(word_to_byte(HOST_DW'(idx_q),   HOST_DW'(BYTE_LEN)));
  assign st_addr_nxt = STORE_BASE + SYS_DWIDTH'(word_to_byte(HOST_DW'(idx_inc), HOST_DW'(BYTE_LEN)));

  // The top parks in PRE for the whole handshake; the sub-FSM walks
  // PRE/START/WAIT_DONE/WAIT_CLR and reports back with 'finished'.
  cgra_start_done_hs u_hs (
    .clk               (Clk),
    .rst               (Rst),
    .go                (hs_go),
    .computation_done  (bus.Computation_Done),
    .computation_start (hs_start),
    .error             (hs_error),
    .finished          (hs_finished)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    load_len_d   = load_len_q;
    store_len_d  = store_len_q;
    in_ready_d   = in_ready_q;
    bram_en_d    = 1'b0;        // BRAM strobes are single-cycle
    bram_wen_d   = '0;
    bram_addr_d  = bram_addr_q;
    bram_wdata_d = bram_wdata_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    hs_go        = 1'b0;
    case (state_q)
      IDLE: if (bus.Cmd_Valid) begin
        load_len_d  = bus.Cmd_Load_Len;
        store_len_d = bus.Cmd_Store_Len;
        idx_d       = '0;
        if (bus.Cmd_Load_Len != '0) begin
          state_d    = LOAD;
          in_ready_d = 1'b1;
        end else begin
          state_d = PRE;
          hs_go   = 1'b1;
        end
      end
      LOAD: if (bus.In_Valid && in_ready_q) begin
        bram_en_d    = 1'b1;
        bram_wen_d   = {BYTE_LEN{1'b1}};
        bram_addr_d  = ld_addr;
        bram_wdata_d = bus.In_Data;
        idx_d        = idx_inc;
        if (idx_q == load_len_q - LEN_W'(1)) begin
          in_ready_d = 1'b0;
          state_d    = PRE;
          hs_go      = 1'b1;
        end
      end
      PRE: if (hs_finished) begin
        idx_d = '0;
        if (store_len_q != '0) begin
          state_d     = RD;
          bram_en_d   = 1'b1;
          bram_addr_d = STORE_BASE;
        end else begin
          state_d = IDLE;
        end
      end
      RD:  state_d = CAP;
      CAP: begin
        out_data_d  = bus.Bram_Data_From_Bram;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: if (bus.Out_Ready) begin
        out_valid_d = 1'b0;
        if (idx_q == store_len_q - LEN_W'(1)) begin
          state_d = IDLE;
        end else begin
          idx_d       = idx_inc;
          state_d     = RD;
          bram_en_d   = 1'b1;
          bram_addr_d = st_addr_nxt;
        end
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      load_len_q   <= '0;
      store_len_q  <= '0;
      cmd_ready_q  <= 1'b1;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      bram_en_q    <= 1'b0;
      bram_wen_q   <= '0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      load_len_q   <= load_len_d;
      store_len_q  <= store_len_d;
      cmd_ready_q  <= cmd_ready_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      bram_en_q    <= bram_en_d;
      bram_wen_q   <= bram_wen_d;
      bram_addr_q  <= bram_addr_d;
      bram_wdata_q <= bram_wdata_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  assign bus.Cmd_Ready         = cmd_ready_q;
  assign bus.In_Ready          = in_ready_q;
  assign bus.Out_Valid         = out_valid_q;
  assign bus.Out_Data          = out_data_q;
  assign bus.Bram_En           = bram_en_q;
  assign bus.Bram_Wen          = bram_wen_q;
  assign bus.Bram_Addr         = bram_addr_q;
  assign bus.Bram_Data_To_Bram = bram_wdata_q;
  assign bus.Computation_Start = hs_start;
  assign bus.Busy              = busy_q;
  assign bus.Error             = hs_error;

endmodule
